// File: rtl/vc_pipe_drop_unit.sv
// vc_pipe_drop_unit
//
// Response filter between the instruction-memory response port and the
// fetch stage. It tracks how many memory requests are outstanding. When the
// fetch stage is squashed, it silently consumes the responses that belong to
// the squashed path. Responses for the redirected path pass through
// combinationally. The payload is never buffered: the only state is the
// two counters.
//
// Parameters:
//   p_msg_nbits    - response payload width
//   p_max_inflight - maximum outstanding requests (>= 1)
//   p_cnt_nbits    - counter width, must be able to hold p_max_inflight
//
// Ports:
//   clk, reset     - single clock, synchronous active-high reset
//   req_go         - a memory request is issued this cycle (counted when req_rdy)
//   req_rdy        - another request may be issued (registered state only)
//   squash         - aggregated squash from the fetch stage
//   in_msg/in_val  - memory response payload / valid
//   in_rdy         - response accepted (either forwarded or dropped)
//   out_msg/out_val- surviving response to the fetch stage
//   out_rdy        - fetch stage can accept
//   inflight       - outstanding request count
//   drop_cnt       - responses still to be discarded
module vc_pipe_drop_unit #(
   parameter int p_msg_nbits    = 32,
   parameter int p_max_inflight = 4,
   parameter int p_cnt_nbits    = 3
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   req_go,
   output logic                   req_rdy,
   input  logic                   squash,
   input  logic [p_msg_nbits-1:0] in_msg,
   input  logic                   in_val,
   output logic                   in_rdy,
   output logic [p_msg_nbits-1:0] out_msg,
   output logic                   out_val,
   input  logic                   out_rdy,
   output logic [p_cnt_nbits-1:0] inflight,
   output logic [p_cnt_nbits-1:0] drop_cnt
);

   localparam logic [p_cnt_nbits-1:0] MAX_INFLIGHT = p_cnt_nbits'(p_max_inflight);

   logic                   any_inflight;
   logic                   drop_now;
   logic                   req_fire;
   logic                   resp_fire;
   logic [p_cnt_nbits:0]   inflight_sum;
   logic [p_cnt_nbits-1:0] inflight_nxt;
   logic [p_cnt_nbits-1:0] drop_nxt;

   // The response currently on the port belongs to the squashed path. This
   // holds during the squash cycle itself and for as long as drops remain.
   assign drop_now     = squash || (drop_cnt != '0);
   assign any_inflight = (inflight != '0);

   // A response with no outstanding request is never accepted. Dropped
   // responses ignore out_rdy, so draining continues while fetch is stalled.
   assign in_rdy    = any_inflight && (drop_now || out_rdy);
   assign out_val   = in_val && any_inflight && !drop_now;
   assign out_msg   = in_msg;

   assign req_rdy   = (inflight != MAX_INFLIGHT);
   assign req_fire  = req_go && req_rdy;
   assign resp_fire = in_val && in_rdy;

   // The sum is formed one bit wider. req_fire is only possible below the
   // maximum and resp_fire only above zero, so the result always fits back
   // into the counter width.
   assign inflight_sum = {1'b0, inflight}
                       + (p_cnt_nbits+1)'(req_fire)
                       - (p_cnt_nbits+1)'(resp_fire);
   assign inflight_nxt = inflight_sum[p_cnt_nbits-1:0];

   // On squash, every old-path request not consumed this cycle becomes a
   // drop. A request fired in the same cycle is the redirected path and is
   // excluded because the reload uses the current inflight. A repeated squash
   // reloads the count, which already covers any drops still pending.
   always_comb begin
      drop_nxt = drop_cnt;
      if (squash)
         drop_nxt = inflight - p_cnt_nbits'(resp_fire);
      else if (resp_fire && (drop_cnt != '0))
         drop_nxt = drop_cnt - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         inflight <= '0;
         drop_cnt <= '0;
      end else begin
         inflight <= inflight_nxt;
         drop_cnt <= drop_nxt;
      end
   end

   // The widened sum cannot overflow. Its top bit is kept only so that the
   // arithmetic is explicit.
   logic unused_sum_msb;
   assign unused_sum_msb = inflight_sum[p_cnt_nbits];

endmodule

// File: tb/tb_vc_pipe_drop_unit.sv
module tb_vc_pipe_drop_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_go;
   logic        req_rdy;
   logic        squash;
   logic [31:0] in_msg;
   logic        in_val;
   logic        in_rdy;
   logic [31:0] out_msg;
   logic        out_val;
   logic        out_rdy;
   logic [2:0]  inflight;
   logic [2:0]  drop_cnt;

   int nvec = 0;
   int nmis = 0;

   vc_pipe_drop_unit #(
      .p_msg_nbits(32),
      .p_max_inflight(4),
      .p_cnt_nbits(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .req_go(req_go),
      .req_rdy(req_rdy),
      .squash(squash),
      .in_msg(in_msg),
      .in_val(in_val),
      .in_rdy(in_rdy),
      .out_msg(out_msg),
      .out_val(out_val),
      .out_rdy(out_rdy),
      .inflight(inflight),
      .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      if (obs !== exp) begin
         nmis++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance past the next rising edge; inputs are then changed safely.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic issue(input int n);
      for (int i = 0; i < n; i++) begin
         req_go = 1'b1;
         tick();
      end
      req_go = 1'b0;
   endtask

   task automatic idle_inputs();
      req_go = 1'b0;
      squash = 1'b0;
      in_val = 1'b0;
      in_msg = 32'h0;
      out_rdy = 1'b1;
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      in_val = 1'b1;
      settle();
      chk("rst_inflight", 32'(inflight), 32'd0);
      chk("rst_drop", 32'(drop_cnt), 32'd0);
      chk("rst_req_rdy", 32'(req_rdy), 32'd1);
      chk("rst_in_rdy", 32'(in_rdy), 32'd0);
      chk("rst_out_val", 32'(out_val), 32'd0);
      in_val = 1'b0;

      // In-order pass-through of three responses
      for (int i = 1; i <= 3; i++) begin
         req_go = 1'b1;
         tick();
         chk("t1_inflight_up", 32'(inflight), 32'(i));
      end
      req_go = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_val = 1'b1;
         in_msg = 32'hA000_0000 + 32'(i);
         settle();
         chk("t1_out_val", 32'(out_val), 32'd1);
         chk("t1_out_msg", out_msg, 32'hA000_0000 + 32'(i));
         chk("t1_in_rdy", 32'(in_rdy), 32'd1);
         tick();
         chk("t1_inflight_dn", 32'(inflight), 32'(2 - i));
         chk("t1_drop", 32'(drop_cnt), 32'd0);
      end
      in_val = 1'b0;

      // Squash with redirected request in the same cycle
      issue(3);
      squash = 1'b1;
      req_go = 1'b1;
      settle();
      chk("t2_sq_in_rdy", 32'(in_rdy), 32'd1);
      tick();
      squash = 1'b0;
      req_go = 1'b0;
      chk("t2_drop", 32'(drop_cnt), 32'd3);
      chk("t2_inflight", 32'(inflight), 32'd4);
      out_rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_val = 1'b1;
         in_msg = 32'hB000_0000 + 32'(i);
         settle();
         chk("t2_drop_in_rdy", 32'(in_rdy), 32'd1);
         chk("t2_drop_out_val", 32'(out_val), 32'd0);
         tick();
         chk("t2_drop_dec", 32'(drop_cnt), 32'(2 - i));
         chk("t2_inflight_dec", 32'(inflight), 32'(3 - i));
      end
      out_rdy = 1'b1;
      in_msg = 32'hB000_0100;
      settle();
      chk("t2_pass_out_val", 32'(out_val), 32'd1);
      chk("t2_pass_msg", out_msg, 32'hB000_0100);
      tick();
      in_val = 1'b0;
      chk("t2_inflight_end", 32'(inflight), 32'd0);

      // Squash coinciding with a response
      issue(2);
      squash = 1'b1;
      in_val = 1'b1;
      settle();
      chk("t3_sq_in_rdy", 32'(in_rdy), 32'd1);
      chk("t3_sq_out_val", 32'(out_val), 32'd0);
      tick();
      squash = 1'b0;
      chk("t3_drop", 32'(drop_cnt), 32'd1);
      chk("t3_inflight", 32'(inflight), 32'd1);
      settle();
      chk("t3_drop2_out_val", 32'(out_val), 32'd0);
      chk("t3_drop2_in_rdy", 32'(in_rdy), 32'd1);
      tick();
      chk("t3_drop_end", 32'(drop_cnt), 32'd0);
      chk("t3_inflight_end", 32'(inflight), 32'd0);
      settle();
      chk("t3_stray_in_rdy", 32'(in_rdy), 32'd0);
      chk("t3_stray_out_val", 32'(out_val), 32'd0);
      in_val = 1'b0;

      // Fill to the maximum
      issue(4);
      chk("t4_full_inflight", 32'(inflight), 32'd4);
      chk("t4_full_req_rdy", 32'(req_rdy), 32'd0);
      req_go = 1'b1;
      tick();
      req_go = 1'b0;
      chk("t4_blocked_inflight", 32'(inflight), 32'd4);
      in_val = 1'b1;
      tick();
      in_val = 1'b0;
      chk("t4_after_resp_inflight", 32'(inflight), 32'd3);
      chk("t4_after_resp_req_rdy", 32'(req_rdy), 32'd1);
      in_val = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      in_val = 1'b0;
      chk("t4_drained", 32'(inflight), 32'd0);

      // Backpressure from the fetch stage
      issue(1);
      out_rdy = 1'b0;
      in_val = 1'b1;
      in_msg = 32'hC0DE_0001;
      settle();
      chk("t5_stall_in_rdy", 32'(in_rdy), 32'd0);
      chk("t5_stall_out_val", 32'(out_val), 32'd1);
      tick();
      chk("t5_stall_inflight", 32'(inflight), 32'd1);
      chk("t5_stall_drop", 32'(drop_cnt), 32'd0);
      out_rdy = 1'b1;
      settle();
      chk("t5_go_in_rdy", 32'(in_rdy), 32'd1);
      tick();
      in_val = 1'b0;
      chk("t5_go_inflight", 32'(inflight), 32'd0);

      // Reset in the middle of a drain
      issue(3);
      squash = 1'b1;
      req_go = 1'b1;
      tick();
      squash = 1'b0;
      req_go = 1'b0;
      in_val = 1'b1;
      tick();
      in_val = 1'b0;
      chk("t6_pre_inflight", 32'(inflight), 32'd3);
      chk("t6_pre_drop", 32'(drop_cnt), 32'd2);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      in_val = 1'b1;
      settle();
      chk("t6_rst_inflight", 32'(inflight), 32'd0);
      chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
      chk("t6_rst_req_rdy", 32'(req_rdy), 32'd1);
      chk("t6_rst_in_rdy", 32'(in_rdy), 32'd0);
      chk("t6_rst_out_val", 32'(out_val), 32'd0);
      in_val = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
